// File: rtl/core_dispatcher_if.sv
// Bundle of the spawn, run and start signals that connect the cluster's cores
// to the task dispatcher. The master side is the dispatcher; the slave side is the core array.
interface core_dispatcher_if #(
    parameter int N_CORES    = 4,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [N_CORES-1:0]        spawn_req;
    logic [N_CORES*ADDR_W-1:0] spawn_addr;
    logic [N_CORES-1:0]        spawn_ack;
    logic [N_CORES-1:0]        core_run;
    logic [N_CORES-1:0]        core_start;
    logic [ADDR_W-1:0]         core_start_addr;
    logic [CNT_W-1:0]          queue_count;
    logic                      busy;
    logic                      dispatch_err;

    modport master (
        input  spawn_req, spawn_addr, core_run,
        output spawn_ack, core_start, core_start_addr, queue_count, busy, dispatch_err
    );

    modport slave (
        output spawn_req, spawn_addr, core_run,
        input  spawn_ack, core_start, core_start_addr, queue_count, busy, dispatch_err
    );
endinterface

// File: rtl/core_dispatcher.sv
// Task scheduler: queues spawn requests from cores in a FIFO and launches each
// queued start address on the lowest-index idle core, one dispatch at a time.
module core_dispatcher #(
    parameter int N_CORES       = 4,
    parameter int ADDR_W        = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int BOOT_ADDR     = 0,
    parameter int START_TIMEOUT = 15
) (
    input  logic              proc_clock,
    input  logic              proc_reset_n,
    core_dispatcher_if.master bus
);
    localparam int IDX_W = $clog2(N_CORES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_CORES-1:0] start_q, start_d;
    logic [ADDR_W-1:0]  start_addr_q, start_addr_d;
    logic               err_q, err_d;
    logic [N_CORES-1:0] spawn_ack_q, spawn_ack_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  fifo_mem_q [FIFO_DEPTH];

    logic [ADDR_W-1:0]  req_addr [N_CORES];
    logic [N_CORES-1:0] eligible;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               push;
    logic               pop;
    logic [N_CORES-1:0] inflight;
    logic [N_CORES-1:0] free_mask;
    logic               free_valid;
    logic [IDX_W-1:0]   free_idx;

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_addr
        assign req_addr[gi] = bus.spawn_addr[gi*ADDR_W +: ADDR_W];
    end

    // Requests acked this cycle are masked so a held request is never queued twice.
    always_comb begin
        int               sum;
        logic [IDX_W-1:0] cand;
        sum        = 0;
        cand       = '0;
        eligible   = bus.spawn_req & ~spawn_ack_q;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            sum = int'(rr_q) + i;
            if (sum >= N_CORES) begin
                sum = sum - N_CORES;
            end
            cand = IDX_W'(sum);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign push = pick_valid && (count_q < FULL_CNT);

    always_comb begin
        spawn_ack_d = '0;
        rr_d        = rr_q;
        if (push) begin
            spawn_ack_d = N_CORES'(1) << pick_idx;
            rr_d        = (pick_idx == IDX_W'(N_CORES - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_comb begin
        inflight = '0;
        if (state_q != IDLE) begin
            inflight[cur_q] = 1'b1;
        end
        free_mask  = ~bus.core_run & ~inflight;
        free_valid = |free_mask;
        free_idx   = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        timer_d      = timer_q;
        start_d      = '0;
        start_addr_d = start_addr_q;
        err_d        = err_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && free_valid) begin
                    pop          = 1'b1;
                    cur_d        = free_idx;
                    start_d      = N_CORES'(1) << free_idx;
                    start_addr_d = fifo_mem_q[rd_ptr_q];
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT_RUN;
            end
            WAIT_RUN: begin
                if (bus.core_run[cur_q]) begin
                    state_d = IDLE;
                end else begin
                    // The popped task is dropped on timeout; only the sticky error remains.
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TMR_W'(START_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge proc_clock) begin
        if (!proc_reset_n) begin
            fifo_mem_q[0] <= ADDR_W'(BOOT_ADDR);
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= req_addr[pick_idx];
        end
    end

    // Reset leaves the boot address as the only queued task.
    always_ff @(posedge proc_clock) begin
        if (!proc_reset_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            timer_q      <= '0;
            start_q      <= '0;
            start_addr_q <= '0;
            err_q        <= 1'b0;
            spawn_ack_q  <= '0;
            rr_q         <= '0;
            wr_ptr_q     <= PTR_W'(1);
            rd_ptr_q     <= '0;
            count_q      <= CNT_W'(1);
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            timer_q      <= timer_d;
            start_q      <= start_d;
            start_addr_q <= start_addr_d;
            err_q        <= err_d;
            spawn_ack_q  <= spawn_ack_d;
            rr_q         <= rr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign bus.spawn_ack       = spawn_ack_q;
    assign bus.core_start      = start_q;
    assign bus.core_start_addr = start_addr_q;
    assign bus.queue_count     = count_q;
    assign bus.dispatch_err    = err_q;
    assign bus.busy            = (|bus.core_run) || (count_q != '0) || (state_q != IDLE);
endmodule
